// File: rtl/audio_codec_i2s_master.sv
// I2S master: BCLK/LRCK generation, stereo ADC serializer with one-entry holding register, DAC deserializer.
// Serial outputs are registered (1 clk); adc_ready drops while the holding entry is full and recovers at the next frame start.
module audio_codec_i2s_master #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BCLKS = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] adc_left,
    input  logic [DATA_WIDTH-1:0] adc_right,
    input  logic                  adc_valid,
    output logic                  adc_ready,
    output logic [DATA_WIDTH-1:0] dac_left,
    output logic [DATA_WIDTH-1:0] dac_right,
    output logic                  dac_valid,
    output logic                  underrun,
    output logic                  AUD_BCLK,
    output logic                  AUD_ADCLRCK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_ADCDAT,
    input  logic                  AUD_DACDAT
);
    localparam int FRAME = 2 * SLOT_BCLKS;
    localparam int CW    = $clog2(FRAME);
    localparam int DIVW  = $clog2(BCLK_DIV);
    localparam logic [CW-1:0]   C_LAST     = CW'(FRAME - 1);
    localparam logic [CW-1:0]   C_SLOT     = CW'(SLOT_BCLKS);
    localparam logic [CW-1:0]   C_DW       = CW'(DATA_WIDTH);
    localparam logic [DIVW-1:0] C_DIV_LAST = DIVW'(BCLK_DIV - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    state_t r_state, w_state_nx;

    logic [DIVW-1:0]       r_div;
    logic [CW-1:0]         r_cnt;
    logic                  r_bclk, r_lrck, r_adcdat, r_dac_vld, r_full, r_underrun;
    logic [DATA_WIDTH-1:0] r_hold_l, r_hold_r, r_adc_sh_l, r_adc_sh_r;
    logic [DATA_WIDTH-1:0] r_dac_sh_l, r_dac_sh_r, r_dac_l, r_dac_r;

    logic                  w_run, w_tick, w_fall, w_rise, w_wrap, w_frame_start, w_accept;
    logic                  w_right, w_right_nx, w_s_data, w_s_nx_data;
    logic [CW-1:0]         w_cnt_nx, w_s, w_s_nx;
    logic [DATA_WIDTH-1:0] w_cap_l, w_cap_r;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= ST_IDLE;
        else                r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = ST_IDLE;
        if (enable) w_state_nx = ST_RUN;
    end

    // The IDLE->RUN cycle is itself the first frame start.
    assign w_run         = enable && (r_state == ST_RUN);
    assign w_tick        = w_run && (r_div == C_DIV_LAST);
    assign w_fall        = w_tick && r_bclk;
    assign w_rise        = w_tick && !r_bclk;
    assign w_cnt_nx      = (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
    assign w_wrap        = w_fall && (r_cnt == C_LAST);
    assign w_frame_start = enable && ((r_state == ST_IDLE) || w_wrap);
    assign w_accept      = adc_valid && !r_full;

    assign w_right     = (r_cnt >= C_SLOT);
    assign w_s         = w_right ? r_cnt - C_SLOT : r_cnt;
    assign w_s_data    = (w_s >= CW'(1)) && (w_s <= C_DW);
    assign w_right_nx  = (w_cnt_nx >= C_SLOT);
    assign w_s_nx      = w_right_nx ? w_cnt_nx - C_SLOT : w_cnt_nx;
    assign w_s_nx_data = (w_s_nx >= CW'(1)) && (w_s_nx <= C_DW);
    assign w_cap_l     = {r_dac_sh_l[DATA_WIDTH-2:0], AUD_DACDAT};
    assign w_cap_r     = {r_dac_sh_r[DATA_WIDTH-2:0], AUD_DACDAT};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_div    <= '0;
            r_bclk   <= 1'b0;
            r_cnt    <= '0;
            r_lrck   <= 1'b0;
            r_adcdat <= 1'b0;
        end else if (!w_run) begin
            r_div    <= '0;
            r_bclk   <= 1'b0;
            r_cnt    <= '0;
            r_lrck   <= 1'b0;
            r_adcdat <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIVW'(1);
            if (w_tick) r_bclk <= ~r_bclk;
            if (w_fall) begin
                r_cnt    <= w_cnt_nx;
                r_lrck   <= w_right_nx;
                r_adcdat <= w_s_nx_data ? (w_right_nx ? r_adc_sh_r[DATA_WIDTH-1]
                                                      : r_adc_sh_l[DATA_WIDTH-1]) : 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_adc_sh_l <= '0;
            r_adc_sh_r <= '0;
        end else if (w_frame_start) begin
            r_adc_sh_l <= r_full ? r_hold_l : '0;
            r_adc_sh_r <= r_full ? r_hold_r : '0;
        end else if (w_fall && w_s_nx_data) begin
            if (w_right_nx) r_adc_sh_r <= r_adc_sh_r << 1;
            else            r_adc_sh_l <= r_adc_sh_l << 1;
        end
    end

    // With SLOT_BCLKS = DATA_WIDTH+1 the last right bit lands on the output-load edge, hence w_cap_r.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_dac_sh_l <= '0;
            r_dac_sh_r <= '0;
            r_dac_l    <= '0;
            r_dac_r    <= '0;
            r_dac_vld  <= 1'b0;
        end else begin
            r_dac_vld <= 1'b0;
            if (!w_run) begin
                r_dac_sh_l <= '0;
                r_dac_sh_r <= '0;
            end else if (w_rise) begin
                if (w_s_data && !w_right) r_dac_sh_l <= w_cap_l;
                if (w_s_data && w_right)  r_dac_sh_r <= w_cap_r;
                if (r_cnt == C_LAST) begin
                    r_dac_l   <= r_dac_sh_l;
                    r_dac_r   <= w_s_data ? w_cap_r : r_dac_sh_r;
                    r_dac_vld <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_l <= adc_left;
                r_hold_r <= adc_right;
            end
            if (w_frame_start) begin
                r_full <= w_accept;
                if (!r_full) r_underrun <= 1'b1;
            end else if (w_accept) begin
                r_full <= 1'b1;
            end
        end
    end

    assign adc_ready   = !r_full;
    assign dac_left    = r_dac_l;
    assign dac_right   = r_dac_r;
    assign dac_valid   = r_dac_vld;
    assign underrun    = r_underrun;
    assign AUD_BCLK    = r_bclk;
    assign AUD_ADCLRCK = r_lrck;
    assign AUD_DACLRCK = r_lrck;
    assign AUD_ADCDAT  = r_adcdat;
endmodule
